// File: rtl/rv32v_mul_result.sv
// Multiplier result stage: in-order tag FIFO of op context, SEW slice/accumulate, result FIFO to writeback.
// Optional accumulate ops (VMACC/VNMSAC) enabled by defining RV32V_MUL_ACC_EN.
module rv32v_mul_result #(
    parameter int DEPTH     = 4,
    parameter int BIT_WIDTH = 32
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   start,
    input  logic [2:0]             op,
    input  logic [1:0]             sew,
    input  logic [31:0]            vd_old,
    input  logic [4:0]             vd_idx,
    output logic                   issue_ready,
    input  logic                   finished,
    input  logic [2*BIT_WIDTH-1:0] product,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [31:0]            wb_data,
    output logic [4:0]             wb_idx,
    output logic                   wb_illegal,
    output logic                   err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

    logic [DEPTH-1:0][2:0]  t_op;
    logic [DEPTH-1:0][1:0]  t_sew;
    logic [DEPTH-1:0][4:0]  t_idx;
`ifdef RV32V_MUL_ACC_EN
    logic [DEPTH-1:0][31:0] t_vd;
`else
    logic unused_vd_old;
    assign unused_vd_old = ^vd_old;
`endif
    logic [DEPTH-1:0][31:0] r_data;
    logic [DEPTH-1:0][4:0]  r_idx;
    logic [DEPTH-1:0]       r_ill;

    logic [PW-1:0] t_wr, t_rd, r_wr, r_rd;
    logic [CW-1:0] tag_cnt, res_cnt;
    logic          tag_push, tag_pop, res_pop;

    assign issue_ready = ({1'b0, tag_cnt} + {1'b0, res_cnt}) < DEPTH_V;
    assign tag_push    = start && issue_ready;
    assign tag_pop     = finished && (tag_cnt != '0);
    assign wb_valid    = (res_cnt != '0);
    assign res_pop     = wb_valid && wb_ready;
    assign wb_data     = r_data[r_rd];
    assign wb_idx      = r_idx[r_rd];
    assign wb_illegal  = r_ill[r_rd];

    // Result for the product at the tag head.
    logic [2:0]  h_op;
    logic [1:0]  h_sew;
    logic [31:0] mask, lo, hi, res_d;
    logic        ill_d;
    assign h_op  = t_op[t_rd];
    assign h_sew = t_sew[t_rd];

    always_comb begin
        mask = 32'hFFFF_FFFF;
        hi   = product[63:32];
        case (h_sew)
            2'b00: begin mask = 32'h0000_00FF; hi = {24'b0, product[15:8]};  end
            2'b01: begin mask = 32'h0000_FFFF; hi = {16'b0, product[31:16]}; end
            default: ;
        endcase
        lo = product[31:0] & mask;
`ifdef RV32V_MUL_ACC_EN
        ill_d = (h_sew == 2'b11) || (h_op > 3'd5);
`else
        ill_d = (h_sew == 2'b11) || h_op[2];
`endif
        res_d = lo;
        if (ill_d) res_d = product[31:0];
        else begin
            case (h_op)
                3'd1, 3'd2, 3'd3: res_d = hi;
`ifdef RV32V_MUL_ACC_EN
                3'd4: res_d = (lo + t_vd[t_rd]) & mask;
                3'd5: res_d = (t_vd[t_rd] - lo) & mask;
`endif
                default: res_d = lo;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            t_wr    <= '0;
            t_rd    <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            tag_cnt <= '0;
            res_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (tag_push) t_wr <= t_wr + 1'b1;
            if (tag_pop) begin
                t_rd <= t_rd + 1'b1;
                r_wr <= r_wr + 1'b1;
            end
            if (res_pop) r_rd <= r_rd + 1'b1;
            tag_cnt <= tag_cnt + CW'(tag_push) - CW'(tag_pop);
            res_cnt <= res_cnt + CW'(tag_pop) - CW'(res_pop);
            if ((start && !issue_ready) || (finished && tag_cnt == '0)) err <= 1'b1;
        end
    end

    // Storage is reset so the head fields read zero out of reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            t_op   <= '0;
            t_sew  <= '0;
            t_idx  <= '0;
`ifdef RV32V_MUL_ACC_EN
            t_vd   <= '0;
`endif
            r_data <= '0;
            r_idx  <= '0;
            r_ill  <= '0;
        end else begin
            if (tag_push) begin
                t_op[t_wr]  <= op;
                t_sew[t_wr] <= sew;
                t_idx[t_wr] <= vd_idx;
`ifdef RV32V_MUL_ACC_EN
                t_vd[t_wr]  <= vd_old;
`endif
            end
            if (tag_pop) begin
                r_data[r_wr] <= res_d;
                r_idx[r_wr]  <= t_idx[t_rd];
                r_ill[r_wr]  <= ill_d;
            end
        end
    end
endmodule

// File: tb/tb_rv32v_mul_result.sv
// Directed self-checking bench for rv32v_mul_result (hand-computed expectations).
module tb_rv32v_mul_result;
    logic        tb_CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [1:0]  sew = '0;
    logic [31:0] vd_old = '0;
    logic [4:0]  vd_idx = '0;
    logic        issue_ready;
    logic        finished = 1'b0;
    logic [63:0] product = '0;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [31:0] wb_data;
    logic [4:0]  wb_idx;
    logic        wb_illegal;
    logic        err;

    int passed = 0;
    int total  = 0;

    rv32v_mul_result #(.DEPTH(4), .BIT_WIDTH(32)) dut (
        .CLK(tb_CLK), .nRST(nRST), .start(start), .op(op), .sew(sew),
        .vd_old(vd_old), .vd_idx(vd_idx), .issue_ready(issue_ready),
        .finished(finished), .product(product), .wb_valid(wb_valid),
        .wb_ready(wb_ready), .wb_data(wb_data), .wb_idx(wb_idx),
        .wb_illegal(wb_illegal), .err(err)
    );

    always #5 tb_CLK = ~tb_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge tb_CLK);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [1:0] s, input logic [31:0] v, input logic [4:0] i);
        start = 1'b1; op = o; sew = s; vd_old = v; vd_idx = i;
        tick();
        start = 1'b0;
    endtask

    task automatic fin(input logic [63:0] p);
        finished = 1'b1; product = p;
        tick();
        finished = 1'b0;
    endtask

    // One op through the pipe with wb_ready=1: check result, then drain it.
    task automatic one(input string tag, input logic [2:0] o, input logic [1:0] s, input logic [31:0] v,
                       input logic [4:0] i, input logic [63:0] p, input logic [31:0] ed, input logic ei);
        issue(o, s, v, i);
        fin(p);
        chk({tag, "_valid"}, 32'(wb_valid), 32'd1);
        chk({tag, "_data"}, wb_data, ed);
        chk({tag, "_idx"}, 32'(wb_idx), 32'(i));
        chk({tag, "_ill"}, 32'(wb_illegal), 32'(ei));
        tick();
        chk({tag, "_drained"}, 32'(wb_valid), 32'd0);
    endtask

    initial begin
        #1;
        chk("rst_valid", 32'(wb_valid), 32'd0);
        chk("rst_data", wb_data, 32'd0);
        chk("rst_idx", 32'(wb_idx), 32'd0);
        chk("rst_ill", 32'(wb_illegal), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ready", 32'(issue_ready), 32'd1);
        tick();
        nRST = 1'b1;
        tick();

        one("vmulh32",  3'd1, 2'b10, 32'h0, 5'd3, 64'h0000_4000_0000_0000, 32'h0000_4000, 1'b0);
        one("vmulhsu",  3'd3, 2'b10, 32'h0, 5'd4, 64'hFFFF_C000_0000_0000, 32'hFFFF_C000, 1'b0);
        one("vmul8",    3'd0, 2'b00, 32'h0, 5'd5, 64'h17D, 32'h0000_007D, 1'b0);
        one("vmulhu8",  3'd2, 2'b00, 32'h0, 5'd6, 64'h17D, 32'h0000_0001, 1'b0);
        one("vmulh16",  3'd1, 2'b01, 32'h0, 5'd7, 64'h1234_5678, 32'h0000_1234, 1'b0);
`ifdef RV32V_MUL_ACC_EN
        one("vmacc16",  3'd4, 2'b01, 32'h0000_2000, 5'd8, 64'hEA60, 32'h0000_0A60, 1'b0);
        one("vnmsac16", 3'd5, 2'b01, 32'h0000_F000, 5'd9, 64'hEA60, 32'h0000_05A0, 1'b0);
`else
        one("vmacc16",  3'd4, 2'b01, 32'h0000_2000, 5'd8, 64'hEA60, 32'h0000_EA60, 1'b1);
        one("vnmsac16", 3'd5, 2'b01, 32'h0000_F000, 5'd9, 64'hEA60, 32'h0000_EA60, 1'b1);
`endif
        one("sew11",    3'd0, 2'b11, 32'h0, 5'd10, 64'h1_2345_6789, 32'h2345_6789, 1'b1);
        one("op7",      3'd7, 2'b00, 32'h0, 5'd11, 64'hABCD_0000_1234_5678, 32'h1234_5678, 1'b1);

        // Streaming: start and finished together every cycle.
        op = 3'd0; sew = 2'b10; vd_old = '0;
        for (int k = 0; k < 6; k++) begin
            start    = (k < 5);
            vd_idx   = 5'(k);
            finished = (k >= 1);
            product  = 64'(100 + k - 1);
            tick();
            if (k >= 1) begin
                chk($sformatf("stream_valid%0d", k), 32'(wb_valid), 32'd1);
                chk($sformatf("stream_data%0d", k), wb_data, 32'(100 + k - 1));
                chk($sformatf("stream_idx%0d", k), 32'(wb_idx), 32'(k - 1));
            end
        end
        start = 1'b0; finished = 1'b0;
        tick();
        chk("stream_empty", 32'(wb_valid), 32'd0);
        chk("stream_err", 32'(err), 32'd0);

        // Back-pressure: fill both FIFOs with wb_ready low.
        wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_ready_pre%0d", i), 32'(issue_ready), 32'd1);
            issue(3'd0, 2'b10, 32'h0, 5'(10 + i));
        end
        chk("bp_full", 32'(issue_ready), 32'd0);
        issue(3'd0, 2'b10, 32'h0, 5'd20);
        chk("bp_drop_err", 32'(err), 32'd1);
        for (int i = 0; i < 4; i++) fin(64'(i + 1));
        chk("bp_valid", 32'(wb_valid), 32'd1);
        chk("bp_still_full", 32'(issue_ready), 32'd0);
        chk("bp_hold_data", wb_data, 32'd1);
        tick();
        chk("bp_hold_data2", wb_data, 32'd1);
        chk("bp_hold_idx", 32'(wb_idx), 32'd10);
        wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_data%0d", i), wb_data, 32'(i + 1));
            chk($sformatf("bp_idx%0d", i), 32'(wb_idx), 32'(10 + i));
            tick();
            if (i == 0) chk("bp_ready_back", 32'(issue_ready), 32'd1);
        end
        chk("bp_empty", 32'(wb_valid), 32'd0);

        // Reset mid-traffic.
        for (int i = 0; i < 3; i++) issue(3'd0, 2'b10, 32'h0, 5'(i));
        fin(64'h55);
        nRST = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(wb_valid), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_ready", 32'(issue_ready), 32'd1);
        chk("mid_rst_data", wb_data, 32'd0);
        tick();
        nRST = 1'b1;
        tick();
        chk("post_rst_err0", 32'(err), 32'd0);
        fin(64'h77);
        chk("orphan_err", 32'(err), 32'd1);
        chk("orphan_valid", 32'(wb_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
